// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer port arbiter.
package fb_pkg;

  // Display geometry for one buffer.
  localparam int unsigned FB_H_RES = 320;
  localparam int unsigned FB_V_RES = 240;

  // Default port widths: 320x240 dots fit in 17 address bits, 3-bit colour.
  localparam int unsigned FB_ADDR_W   = 17;
  localparam int unsigned FB_COLOUR_W = 3;

  // Buffer swap sequencing.
  typedef enum logic [1:0] {
    SwapIdle    = 2'd0,
    SwapPending = 2'd1,
    SwapSwap    = 2'd2
  } swap_state_e;

endpackage

// File: rtl/fb_rr_arb2.sv
// Two-requester round-robin grant. Grant is combinational; the priority
// pointer moves to the other requester after every grant.
module fb_rr_arb2 (
  input  logic       vga_clock,
  input  logic       resetn,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // ptr_q high: requester 1 wins a tie.
  logic ptr_q;

  // Tie-break on the pointer, otherwise grant whichever is asking.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // Hand priority to the other requester after each grant.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= 1'b0;
    end else if (gnt[0]) begin
      ptr_q <= 1'b1;
    end else if (gnt[1]) begin
      ptr_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame-buffer RAM port arbiter: one access per cycle, scan-out reads take
// absolute priority, two draw-engine writers share the rest round-robin.
// Optional feature macro FB_DOUBLE_BUFFER_EN: adds a buffer-select address
// MSB and a vblank-synchronised front/back swap. Without it the swap
// handshake still pulses swap_done so frame pacing is unchanged.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W   = FB_ADDR_W,
  parameter int unsigned COLOUR_W = FB_COLOUR_W
) (
  input  logic                vga_clock,
  input  logic                resetn,
  input  logic                scan_req,
  input  logic [ADDR_W-1:0]   scan_addr,
  output logic [COLOUR_W-1:0] scan_data,
  output logic                scan_valid,
  input  logic [1:0]          wr_req,
  input  logic [ADDR_W-1:0]   wr_addr0,
  input  logic [ADDR_W-1:0]   wr_addr1,
  input  logic [COLOUR_W-1:0] wr_data0,
  input  logic [COLOUR_W-1:0] wr_data1,
  output logic [1:0]          wr_gnt,
`ifdef FB_DOUBLE_BUFFER_EN
  output logic [ADDR_W:0]     mem_addr,
`else
  output logic [ADDR_W-1:0]   mem_addr,
`endif
  output logic [COLOUR_W-1:0] mem_wdata,
  output logic                mem_we,
  input  logic [COLOUR_W-1:0] mem_rdata,
  input  logic                vblank,
  input  logic                swap_req,
  output logic                swap_done,
  output logic                buf_sel
);

`ifdef FB_DOUBLE_BUFFER_EN
  localparam int unsigned MemAw = ADDR_W + 1;
`else
  localparam int unsigned MemAw = ADDR_W;
`endif

  logic [1:0]          arb_req;
  logic [1:0]          arb_gnt;
  logic [ADDR_W-1:0]   wr_addr_low;
  logic [COLOUR_W-1:0] wr_data_sel;
  logic [MemAw-1:0]    rd_mem_addr;
  logic [MemAw-1:0]    wr_mem_addr;
  logic                rd_issued_q;
  logic                vblank_q;
  logic                vblank_rise;
  swap_state_e         state_q;

  // A requester still holds its request during its grant cycle; mask it so
  // the already-accepted write is not issued twice.
  assign arb_req = scan_req ? 2'b00 : (wr_req & ~wr_gnt);

  fb_rr_arb2 u_rr_arb2 (
    .vga_clock (vga_clock),
    .resetn    (resetn),
    .req       (arb_req),
    .gnt       (arb_gnt)
  );

  // Select the winning writer and build full RAM addresses.
  always_comb begin
    wr_addr_low = arb_gnt[1] ? wr_addr1 : wr_addr0;
    wr_data_sel = arb_gnt[1] ? wr_data1 : wr_data0;
`ifdef FB_DOUBLE_BUFFER_EN
    rd_mem_addr = {buf_sel, scan_addr};
    wr_mem_addr = {~buf_sel, wr_addr_low};
`else
    rd_mem_addr = scan_addr;
    wr_mem_addr = wr_addr_low;
`endif
  end

  // Registered RAM port, grant pulse and read-data qualifier pipeline.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      wr_gnt      <= 2'b00;
      rd_issued_q <= 1'b0;
      scan_valid  <= 1'b0;
    end else begin
      rd_issued_q <= scan_req;
      scan_valid  <= rd_issued_q;
      wr_gnt      <= arb_gnt;
      mem_we      <= |arb_gnt;
      if (scan_req) begin
        mem_addr <= rd_mem_addr;
      end else if (|arb_gnt) begin
        // buf_sel is sampled here, so a swap landing next cycle cannot
        // redirect this write.
        mem_addr  <= wr_mem_addr;
        mem_wdata <= wr_data_sel;
      end
    end
  end

  // RAM data arrives one cycle after the address; gate it to keep idle zero.
  assign scan_data = scan_valid ? mem_rdata : '0;

  assign vblank_rise = vblank & ~vblank_q;

`ifdef FB_DOUBLE_BUFFER_EN
  logic buf_q;
  assign buf_sel = buf_q;
`else
  assign buf_sel = 1'b0;
`endif

  // Swap FSM: a request arms on one cycle and fires on a later vblank rise,
  // so a request coinciding with the rise waits a frame.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= SwapIdle;
      vblank_q  <= 1'b0;
      swap_done <= 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
      buf_q     <= 1'b0;
`endif
    end else begin
      vblank_q  <= vblank;
      swap_done <= 1'b0;
      unique case (state_q)
        SwapIdle: begin
          if (swap_req) begin
            state_q <= SwapPending;
          end
        end
        SwapPending: begin
          if (vblank_rise) begin
            state_q   <= SwapSwap;
            swap_done <= 1'b1;
`ifdef FB_DOUBLE_BUFFER_EN
            buf_q     <= ~buf_q;
`endif
          end
        end
        SwapSwap: begin
          state_q <= SwapIdle;
        end
        default: begin
          state_q <= SwapIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: the driver predicts every RAM access,
// grant, read return and swap with a cycle stamp; the monitor pops and
// compares whenever the DUT presents the matching output.
module tb_fb_port_arbiter;
  import fb_pkg::*;

  localparam int unsigned ADDR_W   = FB_ADDR_W;
  localparam int unsigned COLOUR_W = FB_COLOUR_W;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int unsigned MAW = ADDR_W + 1;
  localparam bit          DB  = 1'b1;
`else
  localparam int unsigned MAW = ADDR_W;
  localparam bit          DB  = 1'b0;
`endif

  localparam int IDLE  = 0;
  localparam int WAIT  = 1;
  localparam int ACC   = 2;
  localparam int INGNT = 3;

  logic                vga_clock = 1'b0;
  logic                resetn;
  logic                scan_req;
  logic [ADDR_W-1:0]   scan_addr;
  logic [COLOUR_W-1:0] scan_data;
  logic                scan_valid;
  logic [1:0]          wr_req;
  logic [ADDR_W-1:0]   wr_addr0, wr_addr1;
  logic [COLOUR_W-1:0] wr_data0, wr_data1;
  logic [1:0]          wr_gnt;
  logic [MAW-1:0]      mem_addr;
  logic [COLOUR_W-1:0] mem_wdata;
  logic                mem_we;
  logic [COLOUR_W-1:0] mem_rdata;
  logic                vblank;
  logic                swap_req;
  logic                swap_done;
  logic                buf_sel;

  fb_port_arbiter dut (
    .vga_clock (vga_clock),
    .resetn    (resetn),
    .scan_req  (scan_req),
    .scan_addr (scan_addr),
    .scan_data (scan_data),
    .scan_valid(scan_valid),
    .wr_req    (wr_req),
    .wr_addr0  (wr_addr0),
    .wr_addr1  (wr_addr1),
    .wr_data0  (wr_data0),
    .wr_data1  (wr_data1),
    .wr_gnt    (wr_gnt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .vblank    (vblank),
    .swap_req  (swap_req),
    .swap_done (swap_done),
    .buf_sel   (buf_sel)
  );

  always #5 vga_clock = ~vga_clock;

  typedef struct {
    int                  cyc;
    logic [MAW-1:0]      addr;
    logic [COLOUR_W-1:0] data;
    logic [1:0]          gnt;
    logic                bsel;
  } ev_t;

  ev_t wq[$];   // writes on the RAM port
  ev_t raq[$];  // read addresses on the RAM port
  ev_t rq[$];   // scan_data returns
  ev_t sq[$];   // swap_done pulses

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Environment RAM: synchronous, read-before-write.
  logic [COLOUR_W-1:0] eram[int];

  function automatic logic [COLOUR_W-1:0] dflt(input int a);
    return COLOUR_W'(a ^ (a >> 3) ^ (a >> 7));
  endfunction

  always @(posedge vga_clock) begin : ram_env
    int a;
    a = int'(mem_addr);
    mem_rdata <= eram.exists(a) ? eram[a] : dflt(a);
    if (mem_we === 1'b1) eram[a] = mem_wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the due expectation.
  ev_t me;
  always @(negedge vga_clock) begin
    if (resetn === 1'b1) begin
      if (mem_we === 1'b1) begin
        if (wq.size() != 0 && wq[0].cyc == cyc) begin
          me = wq.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(me.addr));
          check("wr_data", 64'(mem_wdata), 64'(me.data));
          check("wr_gnt", 64'(wr_gnt), 64'(me.gnt));
        end else begin
          check("write_unexpected", 64'(mem_we), 64'd0);
        end
      end else begin
        check("gnt_idle", 64'(wr_gnt), 64'd0);
        if (wq.size() != 0 && wq[0].cyc == cyc) begin
          check("write_missing", 64'(mem_we), 64'd1);
          void'(wq.pop_front());
        end
      end
      if (raq.size() != 0 && raq[0].cyc == cyc) begin
        me = raq.pop_front();
        check("rd_addr", 64'(mem_addr), 64'(me.addr));
        check("rd_we", 64'(mem_we), 64'd0);
      end
      if (scan_valid === 1'b1) begin
        if (rq.size() != 0 && rq[0].cyc == cyc) begin
          me = rq.pop_front();
          check("scan_data", 64'(scan_data), 64'(me.data));
        end else begin
          check("scan_valid_unexpected", 64'(scan_valid), 64'd0);
        end
      end else if (rq.size() != 0 && rq[0].cyc == cyc) begin
        check("scan_valid_missing", 64'(scan_valid), 64'd1);
        void'(rq.pop_front());
      end
      if (swap_done === 1'b1) begin
        if (sq.size() != 0 && sq[0].cyc == cyc) begin
          me = sq.pop_front();
          check("swap_buf_sel", 64'(buf_sel), 64'(me.bsel));
        end else begin
          check("swap_done_unexpected", 64'(swap_done), 64'd0);
        end
      end else if (sq.size() != 0 && sq[0].cyc == cyc) begin
        check("swap_done_missing", 64'(swap_done), 64'd1);
        void'(sq.pop_front());
      end
    end
  end

  // Reference model state.
  logic [COLOUR_W-1:0] mram[int];
  bit                  vb_prev;
  bit                  pending;
  bit                  buf_m;
  int                  swap_cyc;
  int                  toggle_at;
  int                  rr_pref;
  int                  st[2];
  logic [ADDR_W-1:0]   ra[2];
  logic [COLOUR_W-1:0] rdat[2];

  function automatic logic [MAW-1:0] maddr(input bit b, input logic [ADDR_W-1:0] a);
    logic [MAW-1:0] r;
    r = MAW'(a);
    if (DB) r[MAW-1] = b;
    return r;
  endfunction

  function automatic logic [COLOUR_W-1:0] mread(input int a);
    return mram.exists(a) ? mram[a] : dflt(a);
  endfunction

  task automatic model_reset();
    wq.delete(); raq.delete(); rq.delete(); sq.delete();
    vb_prev = 1'b0; pending = 1'b0; buf_m = 1'b0;
    swap_cyc = -10; toggle_at = -10; rr_pref = 0;
    st[0] = IDLE; st[1] = IDLE;
    mram = eram;
  endtask

  // One clock cycle: apply inputs just after the edge and predict responses.
  task automatic step(input bit s_req, input logic [ADDR_W-1:0] s_addr,
                      input bit n0, input bit n1, input bit vb, input bit sw);
    ev_t e;
    int g;
    logic [MAW-1:0] a;
    @(posedge vga_clock);
    #1;
    cyc++;
    if (cyc == toggle_at) buf_m = buf_m ^ DB;
    for (int i = 0; i < 2; i++) begin
      if (st[i] == INGNT) st[i] = IDLE;
      else if (st[i] == ACC) st[i] = INGNT;
      if (st[i] == IDLE && (i == 0 ? n0 : n1)) begin
        st[i]   = WAIT;
        ra[i]   = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 31));
        rdat[i] = COLOUR_W'($urandom);
      end
    end
    wr_req    = {st[1] == WAIT || st[1] == INGNT, st[0] == WAIT || st[0] == INGNT};
    wr_addr0  = ra[0];
    wr_addr1  = ra[1];
    wr_data0  = rdat[0];
    wr_data1  = rdat[1];
    scan_req  = s_req;
    scan_addr = s_addr;
    vblank    = vb;
    swap_req  = sw;
    e = '{cyc: 0, addr: '0, data: '0, gnt: 2'b00, bsel: 1'b0};
    if (s_req) begin
      a = maddr(buf_m, s_addr);
      e.cyc = cyc + 1; e.addr = a; raq.push_back(e);
      e.cyc = cyc + 2; e.data = mread(int'(a)); rq.push_back(e);
    end else begin
      g = -1;
      if (st[0] == WAIT && st[1] == WAIT) g = rr_pref;
      else if (st[0] == WAIT) g = 0;
      else if (st[1] == WAIT) g = 1;
      if (g >= 0) begin
        a = maddr(!buf_m, ra[g]);
        mram[int'(a)] = rdat[g];
        e.cyc = cyc + 1; e.addr = a; e.data = rdat[g]; e.gnt = 2'(1 << g);
        wq.push_back(e);
        st[g]   = ACC;
        rr_pref = 1 - g;
      end
    end
    if (pending && vb && !vb_prev) begin
      pending   = 1'b0;
      swap_cyc  = cyc + 1;
      toggle_at = cyc + 1;
      e.cyc = cyc + 1; e.bsel = buf_m ^ DB; sq.push_back(e);
    end else if (!pending && cyc != swap_cyc && sw) begin
      pending = 1'b1;
    end
    vb_prev = vb;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_scan_data"}, 64'(scan_data), 64'd0);
    check({tag, "_scan_valid"}, 64'(scan_valid), 64'd0);
    check({tag, "_wr_gnt"}, 64'(wr_gnt), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_swap_done"}, 64'(swap_done), 64'd0);
    check({tag, "_buf_sel"}, 64'(buf_sel), 64'd0);
  endtask

  task automatic drive_idle();
    scan_req = 1'b0; scan_addr = '0; wr_req = 2'b00;
    wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
    vblank = 1'b0; swap_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    drive_idle();
    model_reset();
    repeat (3) @(posedge vga_clock);
    #1;
    check_all_zero("reset");
    #2;
    resetn = 1'b1;
    idle(3);

    // Read latency with buf_sel = 0.
    step(1'b1, ADDR_W'(32'h00123), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Both writers contending: alternating grants into the back buffer.
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);

    // Scan traffic starves writer 0 until it drops.
    for (int i = 0; i < 100; i++) step(1'b1, ADDR_W'($urandom_range(0, 31)), 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Swap timing; the second request while pending is ignored.
    for (int i = 0; i < 50; i++)
      step(1'b0, '0, 1'b0, 1'b0, (i >= 40 && i < 45), (i == 5 || i == 20));
    idle(2);

    // Request on the rising-edge cycle waits a frame.
    for (int i = 0; i < 40; i++)
      step(1'b0, '0, 1'b0, 1'b0, ((i >= 10 && i < 15) || (i >= 30 && i < 35)), (i == 10));
    idle(2);

    // Randomised mix with periodic vertical blanking.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 99) < 40), ADDR_W'($urandom_range(0, 31)),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
           ((i % 64) >= 54), ($urandom_range(0, 99) < 3));
    idle(4);

    // Reset with a swap pending and a write accepted but not yet issued.
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    drive_idle();
    wq.delete(); raq.delete(); rq.delete(); sq.delete();
    #1;
    check_all_zero("midreset");
    @(negedge vga_clock);
    check("midreset_no_we", 64'(mem_we), 64'd0);
    @(posedge vga_clock);
    #3;
    model_reset();
    resetn = 1'b1;
    for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b0, 1'b0, (i >= 10 && i < 15), 1'b0);
    @(negedge vga_clock);
    check("post_reset_buf_sel", 64'(buf_sel), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(6);

    @(negedge vga_clock);
    check("wr_queue_drained", 64'(wq.size()), 64'd0);
    check("rd_addr_queue_drained", 64'(raq.size()), 64'd0);
    check("scan_queue_drained", 64'(rq.size()), 64'd0);
    check("swap_queue_drained", 64'(sq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
